// File: rtl/alarm_snooze_ctrl_if.sv
// Signal bundle between the alarm sounding controller and its surroundings.
// The master side supplies time, alarm setting and button levels. The slave
// side (the controller) returns the sounder drive and the status flags.
interface alarm_snooze_ctrl_if;
    logic        one_second;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic        alarm_enable;
    logic        stop_button;
    logic        snooze_button;
    logic        alarm;
    logic        snooze_active;
    logic [2:0]  snooze_count;
    logic        missed_alarm;

    modport master (
        output one_second, current_time, alarm_time, alarm_enable,
               stop_button, snooze_button,
        input  alarm, snooze_active, snooze_count, missed_alarm
    );

    modport slave (
        input  one_second, current_time, alarm_time, alarm_enable,
               stop_button, snooze_button,
        output alarm, snooze_active, snooze_count, missed_alarm
    );
endinterface

// File: rtl/alarm_snooze_ctrl.sv
// Alarm sounding controller: detects the rising edge of a time/alarm match,
// then sequences RINGING, SNOOZE and ring auto-off.
// Snooze support (SNOOZE state, snooze counter path, snooze button edge) is
// built only when the macro ALARM_SNOOZE_EN is defined. Without it, snooze
// outputs are tied to 0 and RINGING ends only by stop, timeout or disable.
module alarm_snooze_ctrl #(
    parameter int SNOOZE_SECS = 300,
    parameter int RING_SECS   = 60,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    alarm_snooze_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    localparam logic [9:0] RING_LAST = 10'(RING_SECS - 1);

    state_t      state;
    logic [9:0]  sec_cnt;
    logic        alarm_r;
    logic        missed_r;
    logic        match;
    logic        match_q;
    logic        trigger;
    logic        stop_q;
    logic        stop_e;

    // match_q resets to 1 so a match present at reset release does not fire
    assign match   = (bus.current_time == bus.alarm_time);
    assign trigger = match & ~match_q & bus.alarm_enable;
    assign stop_e  = bus.stop_button & ~stop_q;

`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    logic        snz_q;
    logic        snz_e;
    logic        snooze_active_r;
    logic [2:0]  snooze_count_r;

    assign snz_e             = bus.snooze_button & ~snz_q;
    assign bus.snooze_active = snooze_active_r;
    assign bus.snooze_count  = snooze_count_r;

    // Snooze button history for rising-edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) snz_q <= 1'b0;
        else          snz_q <= bus.snooze_button;
    end
`else
    assign bus.snooze_active = 1'b0;
    assign bus.snooze_count  = 3'd0;
`endif

    assign bus.alarm        = alarm_r;
    assign bus.missed_alarm = missed_r;

    // Match and stop button history for edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b1;
            stop_q  <= 1'b0;
        end else begin
            match_q <= match;
            stop_q  <= bus.stop_button;
        end
    end

    // Alarm FSM with shared second counter and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sec_cnt  <= 10'd0;
            alarm_r  <= 1'b0;
            missed_r <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_active_r <= 1'b0;
            snooze_count_r  <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sec_cnt <= 10'd0;
                    if (trigger) begin
                        state   <= RINGING;
                        alarm_r <= 1'b1;
`ifdef ALARM_SNOOZE_EN
                        snooze_count_r <= 3'd0;
`endif
                    end else if (stop_e) begin
                        missed_r <= 1'b0;
                    end
                end
                RINGING: begin
                    if (!bus.alarm_enable || stop_e) begin
                        state   <= IDLE;
                        alarm_r <= 1'b0;
                        sec_cnt <= 10'd0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snz_e && (snooze_count_r < SNOOZE_MAX)) begin
                        state           <= SNOOZE;
                        alarm_r         <= 1'b0;
                        snooze_active_r <= 1'b1;
                        snooze_count_r  <= snooze_count_r + 3'd1;
                        sec_cnt         <= 10'd0;
`endif
                    end else if (bus.one_second && (sec_cnt == RING_LAST)) begin
                        state    <= IDLE;
                        alarm_r  <= 1'b0;
                        missed_r <= 1'b1;
                        sec_cnt  <= 10'd0;
                    end else if (bus.one_second) begin
                        sec_cnt <= sec_cnt + 10'd1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (!bus.alarm_enable || stop_e) begin
                        state           <= IDLE;
                        snooze_active_r <= 1'b0;
                        sec_cnt         <= 10'd0;
                    end else if (bus.one_second && (sec_cnt == SNOOZE_LAST)) begin
                        state           <= RINGING;
                        snooze_active_r <= 1'b0;
                        alarm_r         <= 1'b1;
                        sec_cnt         <= 10'd0;
                    end else if (bus.one_second) begin
                        sec_cnt <= sec_cnt + 10'd1;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    alarm_r <= 1'b0;
                    sec_cnt <= 10'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl (RING_SECS=4, SNOOZE_SECS=5,
// MAX_SNOOZE=3). Snooze scenarios are built when ALARM_SNOOZE_EN is defined,
// and the snooze-disabled behaviour is checked otherwise.
module tb_alarm_snooze_ctrl;
    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    alarm_snooze_ctrl_if bus ();

    alarm_snooze_ctrl #(
        .SNOOZE_SECS (5),
        .RING_SECS   (4),
        .MAX_SNOOZE  (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        bus.one_second = 1'b1;
        tick();
        bus.one_second = 1'b0;
        tick();
    endtask

    task automatic retrigger();
        bus.current_time = 16'h0731;
        tick();
        bus.current_time = 16'h0730;
        tick();
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.one_second    = 1'b0;
        bus.current_time  = 16'h0730;
        bus.alarm_time    = 16'h0730;
        bus.alarm_enable  = 1'b1;
        bus.stop_button   = 1'b0;
        bus.snooze_button = 1'b0;
        repeat (3) tick();
        check("reset_alarm", 16'(bus.alarm), 16'h0);
        check("reset_snooze_active", 16'(bus.snooze_active), 16'h0);
        check("reset_snooze_count", 16'(bus.snooze_count), 16'h0);
        check("reset_missed", 16'(bus.missed_alarm), 16'h0);

        // Match present at reset release must not fire
        reset_n = 1'b1;
        repeat (3) tick();
        check("no_fire_after_reset", 16'(bus.alarm), 16'h0);

        // 0729 -> 0730 fires one clock later
        bus.current_time = 16'h0729;
        tick();
        check("no_alarm_0729", 16'(bus.alarm), 16'h0);
        bus.current_time = 16'h0730;
        tick();
        check("alarm_on_match", 16'(bus.alarm), 16'h1);

        // Stop, then holding the match does not retrigger
        bus.stop_button = 1'b1;
        tick();
        check("stop_alarm", 16'(bus.alarm), 16'h0);
        repeat (3) tick();
        bus.stop_button = 1'b0;
        repeat (2) tick();
        check("hold_no_retrigger", 16'(bus.alarm), 16'h0);

        // Ring timeout after the 4th pulse
        retrigger();
        check("timeout_start", 16'(bus.alarm), 16'h1);
        repeat (3) pulse();
        check("alarm_after_3_pulses", 16'(bus.alarm), 16'h1);
        check("missed_before_timeout", 16'(bus.missed_alarm), 16'h0);
        pulse();
        check("alarm_after_timeout", 16'(bus.alarm), 16'h0);
        check("missed_set", 16'(bus.missed_alarm), 16'h1);
        bus.stop_button = 1'b1;
        tick();
        check("missed_cleared", 16'(bus.missed_alarm), 16'h0);
        bus.stop_button = 1'b0;
        tick();

        // Disable while ringing
        retrigger();
        check("ring_before_disable", 16'(bus.alarm), 16'h1);
        bus.alarm_enable = 1'b0;
        tick();
        check("disable_ring", 16'(bus.alarm), 16'h0);
        check("disable_missed", 16'(bus.missed_alarm), 16'h0);
        bus.alarm_enable = 1'b1;
        tick();

`ifdef ALARM_SNOOZE_EN
        // Three snoozes, each lasting exactly 5 pulses
        retrigger();
        check("snz_ring_start", 16'(bus.alarm), 16'h1);
        for (int i = 1; i <= 3; i++) begin
            bus.snooze_button = 1'b1;
            tick();
            check("snz_enter_active", 16'(bus.snooze_active), 16'h1);
            check("snz_enter_alarm", 16'(bus.alarm), 16'h0);
            check("snz_enter_count", 16'(bus.snooze_count), 16'(i));
            bus.snooze_button = 1'b0;
            tick();
            if (i == 1) begin
                bus.snooze_button = 1'b1;
                tick();
                check("snz_press_in_snooze", 16'(bus.snooze_active), 16'h1);
                check("snz_press_in_snooze_cnt", 16'(bus.snooze_count), 16'h1);
                bus.snooze_button = 1'b0;
                tick();
            end
            repeat (4) pulse();
            check("snz_after_4", 16'(bus.snooze_active), 16'h1);
            pulse();
            check("snz_expired", 16'(bus.snooze_active), 16'h0);
            check("snz_ring_again", 16'(bus.alarm), 16'h1);
        end
        bus.snooze_button = 1'b1;
        tick();
        check("snz_4th_ignored_alarm", 16'(bus.alarm), 16'h1);
        check("snz_4th_ignored_cnt", 16'(bus.snooze_count), 16'h3);
        bus.snooze_button = 1'b0;
        tick();

        // Stop and snooze edges together -> IDLE, count unchanged
        bus.stop_button   = 1'b1;
        bus.snooze_button = 1'b1;
        tick();
        check("both_alarm", 16'(bus.alarm), 16'h0);
        check("both_active", 16'(bus.snooze_active), 16'h0);
        check("both_count", 16'(bus.snooze_count), 16'h3);
        bus.stop_button   = 1'b0;
        bus.snooze_button = 1'b0;
        tick();

        // New event clears count; disable during SNOOZE -> IDLE
        retrigger();
        check("new_event_count", 16'(bus.snooze_count), 16'h0);
        bus.snooze_button = 1'b1;
        tick();
        bus.snooze_button = 1'b0;
        check("snz_before_disable", 16'(bus.snooze_active), 16'h1);
        bus.alarm_enable = 1'b0;
        tick();
        check("disable_snz_active", 16'(bus.snooze_active), 16'h0);
        check("disable_snz_alarm", 16'(bus.alarm), 16'h0);
        check("disable_snz_count", 16'(bus.snooze_count), 16'h1);
        bus.alarm_enable = 1'b1;
        tick();
`else
        // Snooze button has no effect when snooze is not built
        retrigger();
        bus.snooze_button = 1'b1;
        tick();
        check("nosnz_alarm", 16'(bus.alarm), 16'h1);
        check("nosnz_active", 16'(bus.snooze_active), 16'h0);
        check("nosnz_count", 16'(bus.snooze_count), 16'h0);
        bus.snooze_button = 1'b0;
        repeat (2) pulse();
        check("nosnz_still_ringing", 16'(bus.alarm), 16'h1);
        check("nosnz_active_later", 16'(bus.snooze_active), 16'h0);
        bus.stop_button = 1'b1;
        tick();
        bus.stop_button = 1'b0;
        tick();
`endif

        // Asynchronous reset mid-ring drops the alarm immediately
        retrigger();
        check("ring_before_reset", 16'(bus.alarm), 16'h1);
        reset_n = 1'b0;
        #1;
        check("async_reset_alarm", 16'(bus.alarm), 16'h0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("post_reset_no_fire", 16'(bus.alarm), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alarm_snooze_ctrl.md
# alarm_snooze_ctrl

Alarm sounding controller for the digital alarm clock. It compares the running clock time against the stored alarm time and starts the alarm when they match. It then sequences ringing, snooze and auto-off, and drives the `alarm` output to the sounder. It sits beside the main controller FSM and consumes the same `one_second` pulse and BCD time digits that feed the display path.

## Interface
- `SNOOZE_SECS`, default 300: snooze length in `one_second` pulses; legal range 1..1023.
- `RING_SECS`, default 60: ring auto-off timeout in `one_second` pulses; legal range 1..1023.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; legal range 0..7.
- `clock` input 1: system clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `one_second` input 1: single-cycle pulse, once per second.
- `current_time` input 16: BCD {ms_hour, ls_hour, ms_min, ls_min}, 4 bits each.
- `alarm_time` input 16: BCD alarm setting, same packing as `current_time`.
- `alarm_enable` input 1: level signal; 0 disarms the block.
- `stop_button` input 1: level signal; only its rising edge acts.
- `snooze_button` input 1: level signal; only its rising edge acts.
- `alarm` output 1: sounder drive; 1 only in RINGING.
- `snooze_active` output 1: 1 only in SNOOZE.
- `snooze_count` output 3: snoozes used in the current alarm event.
- `missed_alarm` output 1: sticky flag; set when a ring ends by timeout.

## Operation
- States: IDLE, RINGING, SNOOZE.
- Reset values: state = IDLE, `alarm` = 0, `snooze_active` = 0, `snooze_count` = 0, `missed_alarm` = 0, second counter = 0, button history registers = 0.
- Match detection:
  - `match` = (`current_time` == `alarm_time`), a full 16-bit compare.
  - `match_q` is a registered copy of `match`; it resets to 1.
  - `trigger` = `match` & ~`match_q` & `alarm_enable`.
  - Because `match_q` resets to 1, a match already present when reset releases does not fire.
- Button edges: `stop_e` = `stop_button` & ~`stop_q`; `snz_e` = `snooze_button` & ~`snz_q`.
- IDLE:
  - `trigger` -> RINGING; clear `snooze_count` to 0.
  - `stop_e` clears `missed_alarm`.
- RINGING:
  - `stop_e` -> IDLE.
  - `snz_e` with `snooze_count` < `MAX_SNOOZE` -> SNOOZE; increment `snooze_count`.
  - `snz_e` with `snooze_count` == `MAX_SNOOZE` is ignored.
  - Ring timeout (`RING_SECS` pulses counted) -> IDLE; set `missed_alarm` to 1.
- SNOOZE:
  - `stop_e` -> IDLE.
  - `snz_e` is ignored.
  - Snooze expiry (`SNOOZE_SECS` pulses counted) -> RINGING; `snooze_count` is unchanged.
- Global rule: `alarm_enable` = 0 in any state -> IDLE on the next edge. `snooze_count` holds its value; `missed_alarm` is unchanged.
- Priority within a state, highest first: `alarm_enable` low, then `stop_e`, then `snz_e`, then timeout/expiry.
- `trigger` occurring in RINGING or SNOOZE is ignored; the alarm does not re-arm mid-event.
- Second counter (10 bits, shared by RINGING and SNOOZE):
  - Cleared on every state change.
  - Increments on `one_second`.
  - Timeout or expiry fires on the edge where `one_second` = 1 and count == N-1. Exactly N pulses are counted after state entry.

## Timing
- State and all outputs are registered; there is no combinational path from inputs to outputs.
- `trigger` or a button edge seen before clock edge k: the new state and outputs are visible after edge k (1-cycle latency).
- Timeout: `alarm` falls after the edge that samples the `RING_SECS`-th `one_second` pulse.
- `one_second` coinciding with a state change is not counted in the new state.
- A button held high produces exactly one edge. A button already high when its state is entered does not act.
- Reset assertion mid-ring: `alarm` drops to 0 asynchronously.

## Configuration
- Macro `ALARM_SNOOZE_EN`.
- Defined: full behaviour as above.
- Undefined:
  - SNOOZE state, its counter path and the `snooze_button` logic are not implemented.
  - `snz_e` has no effect.
  - `snooze_active` and `snooze_count` are tied to 0.
  - RINGING leaves only by stop, timeout or `alarm_enable` low.

## Test plan
- Match: `alarm_time` = 16'h0730, `alarm_enable` = 1, `current_time` steps 0729 -> 0730 -> `alarm` = 1 one clock later. Holding 0730 does not retrigger after a stop.
- Reset with `current_time` == `alarm_time` already, then release -> `alarm` stays 0 until the time leaves and re-enters the match.
- Snooze limit (`MAX_SNOOZE` = 3, `SNOOZE_SECS` = 5):
  - Three snooze presses each give exactly 5 pulses of `snooze_active` = 1, then `alarm` = 1 again.
  - A 4th press is ignored; `snooze_count` = 3.
- Timeout (`RING_SECS` = 4): no buttons -> `alarm` falls after the 4th pulse and `missed_alarm` = 1. A later `stop_e` in IDLE clears it.
- Simultaneous edges: `stop_e` and `snz_e` in the same cycle during RINGING -> IDLE, `snooze_count` unchanged. `alarm_enable` dropping during SNOOZE -> IDLE next edge.
- Macro off: `snooze_button` pulses during RINGING are ignored; `snooze_active` = 0 throughout.
